// File: rtl/gpu_wb_post_buffer_if.sv
// Host request port and Wishbone master bus of gpu_wb_post_buffer.
// master = the buffer's view, slave = host request source plus GPU slave.
interface gpu_wb_post_buffer_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [26:0] i_req_addr;
  logic [31:0] i_req_data;
  logic [3:0]  i_req_sel;
  logic        o_rd_valid;
  logic [31:0] o_rd_data;
  logic        o_busy;
  logic        o_err;
  logic        i_err_clr;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [26:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  modport master (
    input  i_req_valid, i_req_we, i_req_addr,
    input  i_req_data, i_req_sel, i_err_clr,
    input  wb_dat_i, wb_ack_i,
    output o_req_ready, o_rd_valid, o_rd_data,
    output o_busy, o_err,
    output wb_cyc_o, wb_stb_o, wb_we_o,
    output wb_sel_o, wb_adr_o, wb_dat_o
  );

  modport slave (
    output i_req_valid, i_req_we, i_req_addr,
    output i_req_data, i_req_sel, i_err_clr,
    output wb_dat_i, wb_ack_i,
    input  o_req_ready, o_rd_valid, o_rd_data,
    input  o_busy, o_err,
    input  wb_cyc_o, wb_stb_o, wb_we_o,
    input  wb_sel_o, wb_adr_o, wb_dat_o
  );
endinterface

// File: rtl/gpu_wb_post_buffer.sv
// Posted request FIFO replayed one at a time as Wishbone classic cycles.
// Bus timeout/abort logic is compiled in with `define GPU_WB_TIMEOUT_EN.
module gpu_wb_post_buffer #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 15
) (
  input logic clk_100MHz,
  input logic wb_rst_i,
  gpu_wb_post_buffer_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, BUS} state_t;

  logic [63:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count;
  logic        full, empty;
  logic        push, pop;
  logic [63:0] head;

  state_t      state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [26:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        rd_valid_q, rd_valid_d;
  logic [31:0] rd_data_q, rd_data_d;

`ifdef GPU_WB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wait_q, wait_d;
  logic       err_q, err_d;
  logic       err_set;
`else
  localparam int unused_timeout = TIMEOUT;
  logic unused_err_clr;
  assign unused_err_clr = bus.i_err_clr;
`endif

  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign push  = bus.i_req_valid && !full;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

  always_ff @(posedge clk_100MHz) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {bus.i_req_we, bus.i_req_addr,
                                  bus.i_req_data, bus.i_req_sel};
    end
  end

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    sel_d      = sel_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    pop        = 1'b0;
`ifdef GPU_WB_TIMEOUT_EN
    wait_d     = wait_q;
    err_set    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          cyc_d   = 1'b1;
          {we_d, adr_d, dat_d, sel_d} = head;
          state_d = BUS;
`ifdef GPU_WB_TIMEOUT_EN
          wait_d  = '0;
`endif
        end
      end
      BUS: begin
        // ack wins over a timeout landing on the same edge
        if (bus.wb_ack_i) begin
          cyc_d   = 1'b0;
          state_d = IDLE;
          if (!we_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = bus.wb_dat_i;
          end
        end
`ifdef GPU_WB_TIMEOUT_EN
        else if (wait_q == TO_LAST) begin
          cyc_d   = 1'b0;
          state_d = IDLE;
          err_set = 1'b1;
          if (!we_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = '0;
          end
        end else begin
          wait_d = wait_q + 8'd1;
        end
`endif
      end
    endcase
  end

`ifdef GPU_WB_TIMEOUT_EN
  assign err_d = err_set ? 1'b1 : (bus.i_err_clr ? 1'b0 : err_q);

  always_ff @(posedge clk_100MHz or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end

  assign bus.o_err = err_q;
`else
  assign bus.o_err = 1'b0;
`endif

  always_ff @(posedge clk_100MHz or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      state_q    <= IDLE;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign bus.o_req_ready = !full;
  assign bus.o_busy      = !empty || (state_q == BUS);
  assign bus.o_rd_valid  = rd_valid_q;
  assign bus.o_rd_data   = rd_data_q;
  assign bus.wb_cyc_o    = cyc_q;
  assign bus.wb_stb_o    = cyc_q;
  assign bus.wb_we_o     = we_q;
  assign bus.wb_sel_o    = sel_q;
  assign bus.wb_adr_o    = adr_q;
  assign bus.wb_dat_o    = dat_q;
endmodule
